// File: rtl/cpu7_csr_wpipe_pkg.sv
// Shared types and defaults for the cpu7 CSR write pipeline.
// Latency: none (types, defaults and a combinational stage-op helper only).
// Backpressure: stage op gives kill priority over hold.
package cpu7_csr_wpipe_pkg;

  localparam int unsigned CSR_ADDR_W_DEF = 14;
  localparam int unsigned CSR_DATA_W_DEF = 32;
  localparam int unsigned CSR_CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    STG_LOAD = 2'd0,
    STG_HOLD = 2'd1,
    STG_KILL = 2'd2
  } stg_op_e;

  function automatic stg_op_e stg_op(input logic hold, input logic kill);
    if (kill)      return STG_KILL;
    else if (hold) return STG_HOLD;
    else           return STG_LOAD;
  endfunction

endpackage

// File: rtl/cpu7_csr_wstage.sv
// One CSR write pipeline stage: valid bit plus address/data, with hold and kill.
// Kill clears only the valid bit; address/data keep whatever they held.
module cpu7_csr_wstage
  import cpu7_csr_wpipe_pkg::*;
#(
  parameter int unsigned ADDR_W = CSR_ADDR_W_DEF,
  parameter int unsigned DATA_W = CSR_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold_i,
  input  logic              kill_i,
  input  logic              vld_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vld_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  logic              vld_q,  vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    case (stg_op(hold_i, kill_i))
      STG_LOAD: begin
        vld_d  = vld_i;
        addr_d = addr_i;
        data_d = data_i;
      end
      STG_KILL: vld_d = 1'b0;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/cpu7_csr_wpipe.sv
// CSR write pipeline D->E->M with a valid/ready commit port out of M.
// E/M feed the D-stage CSR bypass; commit back-pressure freezes both stages.
module cpu7_csr_wpipe
  import cpu7_csr_wpipe_pkg::*;
#(
  parameter int unsigned ADDR_W = CSR_ADDR_W_DEF,
  parameter int unsigned DATA_W = CSR_DATA_W_DEF,
  parameter int unsigned CNT_W  = CSR_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              csr_wen_d,
  input  logic [ADDR_W-1:0] csr_waddr_d,
  input  logic [DATA_W-1:0] csr_wdata_d,
  input  logic              stall,
  input  logic              flush,
  input  logic              csr_commit_ready,
  output logic              csr_wen_e,
  output logic [ADDR_W-1:0] csr_waddr_e,
  output logic [DATA_W-1:0] csr_wdata_e,
  output logic              csr_wen_m,
  output logic [ADDR_W-1:0] csr_waddr_m,
  output logic [DATA_W-1:0] csr_wdata_m,
  output logic              csr_commit_valid,
  output logic [ADDR_W-1:0] csr_commit_addr,
  output logic [DATA_W-1:0] csr_commit_data,
  output logic              csr_stall_req,
  output logic              csr_wr_pending,
  output logic [CNT_W-1:0]  csr_commit_cnt
);

  logic             hold;
  logic             commit_fire;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // An M write waiting on the register file freezes E too, so nothing overtakes it.
  assign hold = stall | (csr_wen_m & ~csr_commit_ready);

  cpu7_csr_wstage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_stage_e (
    .clk    (clk),
    .reset  (reset),
    .hold_i (hold),
    .kill_i (flush),
    .vld_i  (csr_wen_d),
    .addr_i (csr_waddr_d),
    .data_i (csr_wdata_d),
    .vld_o  (csr_wen_e),
    .addr_o (csr_waddr_e),
    .data_o (csr_wdata_e)
  );

  cpu7_csr_wstage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_stage_m (
    .clk    (clk),
    .reset  (reset),
    .hold_i (hold),
    .kill_i (flush),
    .vld_i  (csr_wen_e),
    .addr_i (csr_waddr_e),
    .data_i (csr_wdata_e),
    .vld_o  (csr_wen_m),
    .addr_o (csr_waddr_m),
    .data_o (csr_wdata_m)
  );

  assign csr_commit_valid = csr_wen_m & ~flush & ~stall;
  assign csr_commit_addr  = csr_waddr_m;
  assign csr_commit_data  = csr_wdata_m;
  assign commit_fire      = csr_commit_valid & csr_commit_ready;

  assign csr_stall_req  = csr_wen_m & ~csr_commit_ready & ~flush;
  assign csr_wr_pending = csr_wen_e | csr_wen_m;

  assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, commit_fire};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign csr_commit_cnt = cnt_q;

endmodule

// File: tb/tb_cpu7_csr_wpipe.sv
// Bench for cpu7_csr_wpipe (CNT_W=4): vector table, corner sequences, random stream.
// Commits are scoreboarded against a queue filled as writes are accepted from D.
module tb_cpu7_csr_wpipe;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wen_d, stall, flush, ready;
  logic [AW-1:0] waddr_d;
  logic [DW-1:0] wdata_d;
  logic          wen_e, wen_m, cvld, sreq, pend;
  logic [AW-1:0] waddr_e, waddr_m, caddr;
  logic [DW-1:0] wdata_e, wdata_m, cdata;
  logic [CW-1:0] cnt;

  cpu7_csr_wpipe #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .csr_wen_d        (wen_d),
    .csr_waddr_d      (waddr_d),
    .csr_wdata_d      (wdata_d),
    .stall            (stall),
    .flush            (flush),
    .csr_commit_ready (ready),
    .csr_wen_e        (wen_e),
    .csr_waddr_e      (waddr_e),
    .csr_wdata_e      (wdata_e),
    .csr_wen_m        (wen_m),
    .csr_waddr_m      (waddr_m),
    .csr_wdata_m      (wdata_m),
    .csr_commit_valid (cvld),
    .csr_commit_addr  (caddr),
    .csr_commit_data  (cdata),
    .csr_stall_req    (sreq),
    .csr_wr_pending   (pend),
    .csr_commit_cnt   (cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW+DW-1:0] sb_q[$];
  logic [CW-1:0]    exp_cnt;

  typedef struct {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          stall, flush, ready, push;
    logic          e_wen;
    logic [AW-1:0] e_addr;
    logic          m_wen;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          cvld, sreq;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vt[28];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] all_outs();
    return {wen_e, waddr_e, wdata_e, wen_m, waddr_m, wdata_m,
            cvld, caddr, cdata, sreq, pend, cnt};
  endfunction

  task automatic drive(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic s, input logic f, input logic r);
    wen_d = w; waddr_d = a; wdata_d = d; stall = s; flush = f; ready = r;
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    sb_q.push_back({a, d});
    exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Commit monitor: the handshake seen mid-cycle completes at the coming edge.
  always @(negedge clk) begin
    if (!reset && cvld && ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_commit: got addr %0h data %0h, required no commit", caddr, cdata);
      end else begin
        chk("commit_addr_data", {caddr, cdata}, sb_q.pop_front());
      end
    end
  end

  initial begin
    // wen addr data stall flush ready push | e_wen e_addr m_wen m_addr m_data cvld sreq cnt
    vt[0]  = '{1, 14'h006, 32'hDEADBEEF, 0,0,1,1, 0,14'h000, 0,14'h000,32'h0,        0,0,4'd0};
    vt[1]  = '{0, 14'h000, 32'h0,        0,0,1,0, 1,14'h006, 0,14'h000,32'h0,        0,0,4'd0};
    vt[2]  = '{0, 14'h000, 32'h0,        0,0,1,0, 0,14'h000, 1,14'h006,32'hDEADBEEF, 1,0,4'd0};
    vt[3]  = '{0, 14'h000, 32'h0,        0,0,1,0, 0,14'h000, 0,14'h000,32'h0,        0,0,4'd1};
    vt[4]  = '{1, 14'h006, 32'h11111111, 0,0,1,1, 0,14'h000, 0,14'h000,32'h0,        0,0,4'd1};
    vt[5]  = '{1, 14'h010, 32'h22222222, 0,0,1,1, 1,14'h006, 0,14'h000,32'h0,        0,0,4'd1};
    vt[6]  = '{0, 14'h000, 32'h0,        0,0,0,0, 1,14'h010, 1,14'h006,32'h11111111, 1,1,4'd1};
    vt[7]  = '{0, 14'h000, 32'h0,        0,0,0,0, 1,14'h010, 1,14'h006,32'h11111111, 1,1,4'd1};
    vt[8]  = '{0, 14'h000, 32'h0,        0,0,0,0, 1,14'h010, 1,14'h006,32'h11111111, 1,1,4'd1};
    vt[9]  = '{0, 14'h000, 32'h0,        0,0,1,0, 1,14'h010, 1,14'h006,32'h11111111, 1,0,4'd1};
    vt[10] = '{0, 14'h000, 32'h0,        0,0,1,0, 0,14'h000, 1,14'h010,32'h22222222, 1,0,4'd2};
    vt[11] = '{0, 14'h000, 32'h0,        0,0,1,0, 0,14'h000, 0,14'h000,32'h0,        0,0,4'd3};
    vt[12] = '{1, 14'h000, 32'h33333333, 0,0,1,0, 0,14'h000, 0,14'h000,32'h0,        0,0,4'd3};
    vt[13] = '{1, 14'h001, 32'h44444444, 0,0,1,0, 1,14'h000, 0,14'h000,32'h0,        0,0,4'd3};
    vt[14] = '{0, 14'h000, 32'h0,        0,1,1,0, 1,14'h001, 1,14'h000,32'h33333333, 0,0,4'd3};
    vt[15] = '{0, 14'h000, 32'h0,        0,0,1,0, 0,14'h000, 0,14'h000,32'h0,        0,0,4'd3};
    vt[16] = '{1, 14'h007, 32'h55555555, 0,0,1,0, 0,14'h000, 0,14'h000,32'h0,        0,0,4'd3};
    vt[17] = '{0, 14'h000, 32'h0,        0,0,1,0, 1,14'h007, 0,14'h000,32'h0,        0,0,4'd3};
    vt[18] = '{0, 14'h000, 32'h0,        0,1,0,0, 0,14'h000, 1,14'h007,32'h55555555, 0,0,4'd3};
    vt[19] = '{0, 14'h000, 32'h0,        0,0,1,0, 0,14'h000, 0,14'h000,32'h0,        0,0,4'd3};
    vt[20] = '{1, 14'h020, 32'h66666666, 0,0,1,1, 0,14'h000, 0,14'h000,32'h0,        0,0,4'd3};
    vt[21] = '{1, 14'h021, 32'h77777777, 0,0,1,1, 1,14'h020, 0,14'h000,32'h0,        0,0,4'd3};
    vt[22] = '{1, 14'h022, 32'h88888888, 1,0,1,0, 1,14'h021, 1,14'h020,32'h66666666, 0,0,4'd3};
    vt[23] = '{1, 14'h022, 32'h88888888, 1,0,1,0, 1,14'h021, 1,14'h020,32'h66666666, 0,0,4'd3};
    vt[24] = '{1, 14'h022, 32'h88888888, 0,0,1,1, 1,14'h021, 1,14'h020,32'h66666666, 1,0,4'd3};
    vt[25] = '{0, 14'h000, 32'h0,        0,0,1,0, 1,14'h022, 1,14'h021,32'h77777777, 1,0,4'd4};
    vt[26] = '{0, 14'h000, 32'h0,        0,0,1,0, 0,14'h000, 1,14'h022,32'h88888888, 1,0,4'd5};
    vt[27] = '{0, 14'h000, 32'h0,        0,0,1,0, 0,14'h000, 0,14'h000,32'h0,        0,0,4'd6};

    exp_cnt = '0;
    reset = 1'b1;
    drive(0, '0, '0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outs(), '0);
    next_cycle();
    reset = 1'b0;

    for (int i = 0; i < 28; i++) begin
      drive(vt[i].wen, vt[i].addr, vt[i].data, vt[i].stall, vt[i].flush, vt[i].ready);
      if (vt[i].push) push_exp(vt[i].addr, vt[i].data);
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), {wen_e, wen_m, cvld, sreq, pend, cnt},
          {vt[i].e_wen, vt[i].m_wen, vt[i].cvld, vt[i].sreq, vt[i].e_wen | vt[i].m_wen, vt[i].cnt});
      if (vt[i].e_wen) chk($sformatf("vec%0d_addr_e", i), waddr_e, vt[i].e_addr);
      if (vt[i].m_wen) begin
        chk($sformatf("vec%0d_m", i), {waddr_m, wdata_m}, {vt[i].m_addr, vt[i].m_data});
        chk($sformatf("vec%0d_commit_port", i), {caddr, cdata}, {vt[i].m_addr, vt[i].m_data});
      end
      next_cycle();
    end
    chk("table_scoreboard_empty", sb_q.size(), 0);
    chk("table_cnt", cnt, exp_cnt);

    // Reset in the middle of a back-pressured commit.
    drive(1, 14'h030, 32'hA0A0A0A0, 0, 0, 1);
    next_cycle();
    drive(1, 14'h031, 32'hB1B1B1B1, 0, 0, 1);
    next_cycle();
    drive(0, '0, '0, 0, 0, 0);
    @(negedge clk);
    chk("pre_reset_stall_req", {wen_e, wen_m, cvld, sreq}, 4'b1111);
    #1;
    reset = 1'b1;
    sb_q.delete();
    exp_cnt = '0;
    #1;
    chk("async_reset_outputs", all_outs(), '0);
    next_cycle();
    reset = 1'b0;
    drive(0, '0, '0, 0, 0, 1);
    @(negedge clk);
    chk("post_reset_outputs", all_outs(), '0);
    next_cycle();

    // Counter wrap: 2^CW - 1 commits, then one more.
    for (int i = 0; i < 15; i++) begin
      drive(1, AW'(14'h100 + i), $urandom, 0, 0, 1);
      push_exp(waddr_d, wdata_d);
      next_cycle();
    end
    drive(0, '0, '0, 0, 0, 1);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("cnt_at_max", cnt, 4'd15);
    next_cycle();
    drive(1, 14'h1FF, 32'hCAFEF00D, 0, 0, 1);
    push_exp(waddr_d, wdata_d);
    next_cycle();
    drive(0, '0, '0, 0, 0, 1);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("cnt_wrapped", {pend, cnt}, {1'b0, 4'd0});
    next_cycle();

    // Random stream with stall and ready drops; D holds until E accepts it.
    begin
      logic          have = 1'b0;
      logic [AW-1:0] pa   = '0;
      logic [DW-1:0] pd   = '0;
      for (int c = 0; c < 300; c++) begin
        if (!have && $urandom_range(0, 2) != 0) begin
          have = 1'b1;
          pa   = AW'($urandom);
          pd   = $urandom;
        end
        drive(have, pa, pd, $urandom_range(0, 4) == 0, 0, $urandom_range(0, 2) != 0);
        @(negedge clk);
        if (stall && cvld) begin
          n_checks++;
          n_fail++;
          $display("FAIL commit_valid_in_stall: got 1, required 0 (cycle %0d)", c);
        end
        if (have && !stall && !sreq) begin
          push_exp(pa, pd);
          have = 1'b0;
        end
        next_cycle();
      end
    end
    drive(0, '0, '0, 0, 0, 1);
    for (int c = 0; c < 20 && (sb_q.size() != 0 || pend); c++) next_cycle();
    @(negedge clk);
    chk("random_drain_left", {sb_q.size(), pend}, '0);
    chk("random_cnt", cnt, exp_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
